life_next_gen: RTL and testbench

Computes one Game of Life generation, B3/S23, over the whole grid. It streams rows out of the source line BRAM and keeps a three-row sliding window. From that window it writes each next-state row into the destination line BRAM. It sits directly upstream of the pixel generator: it fills the BRAM that the pixel generator reads as `dout_line_*`, and the two BRAMs swap roles between generations.

---
 rtl/life_pkg.sv | 20 ++
 rtl/life_row_next.sv | 39 +++
 rtl/life_next_gen.sv | 176 +++++++++++++++++
 tb/tb_life_next_gen.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared defaults, FSM states and B3/S23 rule constants for life_next_gen
package life_pkg;

    localparam int LIFE_COLS   = 1280;
    localparam int LIFE_ROWS   = 720;
    localparam int LIFE_ADDR_W = 10;

    localparam logic [3:0] BIRTH_CNT  = 4'd3;
    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } life_state_e;

endpackage

// File: rtl/life_row_next.sv
// rtl/life_row_next.sv - combinational next-state of one row from its three-row window
// LIFE_WRAP_EN: bit COLS-1 and bit 0 are neighbours; otherwise cells beyond the row edges are dead.
module life_row_next
    import life_pkg::*;
#(
    parameter int COLS = LIFE_COLS
) (
    input  logic [COLS-1:0] top_i,
    input  logic [COLS-1:0] mid_i,
    input  logic [COLS-1:0] bot_i,
    output logic [COLS-1:0] next_o
);

    // Padded rows: x[i+1] is bit i, x[COLS+1] is left of bit COLS-1, x[0] is right of bit 0.
    logic [COLS+1:0] top_x, mid_x, bot_x;

`ifdef LIFE_WRAP_EN
    assign top_x = {top_i[0], top_i, top_i[COLS-1]};
    assign mid_x = {mid_i[0], mid_i, mid_i[COLS-1]};
    assign bot_x = {bot_i[0], bot_i, bot_i[COLS-1]};
`else
    assign top_x = {1'b0, top_i, 1'b0};
    assign mid_x = {1'b0, mid_i, 1'b0};
    assign bot_x = {1'b0, bot_i, 1'b0};
`endif

    for (genvar i = 0; i < COLS; i++) begin : g_cell
        logic [3:0] block_sum;
        logic [3:0] nbr_cnt;

        assign block_sum = 4'(top_x[i]) + 4'(top_x[i+1]) + 4'(top_x[i+2])
                         + 4'(mid_x[i]) + 4'(mid_x[i+1]) + 4'(mid_x[i+2])
                         + 4'(bot_x[i]) + 4'(bot_x[i+1]) + 4'(bot_x[i+2]);
        assign nbr_cnt   = block_sum - 4'(mid_x[i+1]);
        assign next_o[i] = (nbr_cnt == BIRTH_CNT)
                         || (mid_i[i] && (nbr_cnt == SURVIVE_LO || nbr_cnt == SURVIVE_HI));
    end

endmodule

// File: rtl/life_next_gen.sv
// rtl/life_next_gen.sv - streams one Game of Life generation from source to destination line BRAM
// LIFE_WRAP_EN: toroidal grid; otherwise the out-of-grid reads are suppressed and zero rows captured.
module life_next_gen
    import life_pkg::*;
#(
    parameter int COLS   = LIFE_COLS,
    parameter int ROWS   = LIFE_ROWS,
    parameter int ADDR_W = LIFE_ADDR_W
) (
    input  logic              out_stream_aclk,
    input  logic              periph_resetn,
    input  logic              start,
    input  logic              pause,
    output logic              busy,
    output logic              done,
    output logic [15:0]       gen_count,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [COLS-1:0]   rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [COLS-1:0]   wr_data
);

    localparam int KW = ADDR_W + 1;
    localparam logic [KW-1:0] K_LAST = KW'(ROWS + 1);

    life_state_e       state_q, state_d;
    logic [KW-1:0]     rk_q, rk_d;
    logic [KW-1:0]     ck_q, ck_d;
    logic              slot_q, slot_d;
    logic              fly_q, fly_d;
    logic              fly_zero_q, fly_zero_d;
    logic [COLS-1:0]   top_q, top_d, mid_q, mid_d;
    logic              busy_q, busy_d, done_q, done_d;
    logic              rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic [15:0]       gen_q, gen_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic [COLS-1:0]   wr_data_q, wr_data_d;
    logic              issue, slot_real;
    logic [ADDR_W-1:0] slot_addr;
    logic [COLS-1:0]   bot_row, next_row;

    // The incoming row is the window bottom, so the write lands in the same edge as the capture.
    assign bot_row = fly_zero_q ? '0 : rd_data;

    life_row_next #(.COLS(COLS)) u_row_next (
        .top_i  (top_q),
        .mid_i  (mid_q),
        .bot_i  (bot_row),
        .next_o (next_row)
    );

    always_comb begin
        issue = !pause && (state_q == ST_FILL || state_q == ST_RUN);
`ifdef LIFE_WRAP_EN
        slot_real = 1'b1;
`else
        slot_real = (rk_q != '0) && (rk_q != K_LAST);
`endif
        if (rk_q == '0) begin
            slot_addr = ADDR_W'(ROWS - 1);
        end else if (rk_q == K_LAST) begin
            slot_addr = '0;
        end else begin
            slot_addr = ADDR_W'(rk_q - KW'(1));
        end
    end

    always_comb begin
        state_d    = state_q;
        rk_d       = rk_q;
        ck_d       = ck_q;
        slot_d     = issue;
        rd_en_d    = issue && slot_real;
        rd_addr_d  = issue ? slot_addr : rd_addr_q;
        fly_d      = slot_q;
        fly_zero_d = slot_q && !rd_en_q;
        top_d      = top_q;
        mid_d      = mid_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        gen_d      = gen_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    rk_d    = '0;
                    ck_d    = '0;
                end
            end
            ST_FILL: begin
                if (issue) begin
                    rk_d = rk_q + KW'(1);
                    if (rk_q == KW'(2)) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    rk_d = rk_q + KW'(1);
                    if (rk_q == K_LAST) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (wr_en_q && wr_addr_q == ADDR_W'(ROWS - 1)) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (fly_q) begin
            top_d = mid_q;
            mid_d = bot_row;
            ck_d  = ck_q + KW'(1);
            if (ck_q >= KW'(2)) begin
                wr_en_d   = 1'b1;
                wr_addr_d = ADDR_W'(ck_q - KW'(2));
                wr_data_d = next_row;
            end
        end

        if (state_d == ST_DONE) gen_d = gen_q + 16'd1;
        done_d = (state_d == ST_DONE);
        busy_d = (state_q != ST_IDLE) && (state_d != ST_DONE) && (state_d != ST_IDLE);
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q    <= ST_IDLE;
            rk_q       <= '0;
            ck_q       <= '0;
            slot_q     <= 1'b0;
            fly_q      <= 1'b0;
            fly_zero_q <= 1'b0;
            top_q      <= '0;
            mid_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            gen_q      <= '0;
            rd_addr_q  <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rk_q       <= rk_d;
            ck_q       <= ck_d;
            slot_q     <= slot_d;
            fly_q      <= fly_d;
            fly_zero_q <= fly_zero_d;
            top_q      <= top_d;
            mid_q      <= mid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_en_q    <= rd_en_d;
            wr_en_q    <= wr_en_d;
            gen_q      <= gen_d;
            rd_addr_q  <= rd_addr_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign gen_count = gen_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_life_next_gen.sv
// tb/tb_life_next_gen.sv - table-driven and randomized bench for life_next_gen against a grid model
module tb_life_next_gen;
    import life_pkg::*;

    localparam int COLS   = 16;
    localparam int ROWS   = 24;
    localparam int ADDR_W = 5;
    localparam int NV     = 8;

    logic              clk = 1'b0;
    logic              periph_resetn;
    logic              start, pause;
    logic              busy, done, rd_en, wr_en;
    logic [15:0]       gen_count;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [COLS-1:0]   rd_data, wr_data;

    logic [COLS-1:0] src_mem [ROWS];
    logic [COLS-1:0] dst_mem [ROWS];
    logic [COLS-1:0] ref_g   [ROWS];
    logic [COLS-1:0] ref_n   [ROWS];

    int total = 0;
    int bad   = 0;
    int exp_gc = 0;

    typedef struct {
        int pat;
        int n_gen;
        int p_at;
        int p_len;
        int s2_at;
        int exp_lat;
        int exp_pw;
    } vec_t;
    vec_t vecs [NV];

    int gl_r [5] = '{0, 1, 2, 2, 2};
    int gl_c [5] = '{1, 2, 0, 1, 2};

    always #5 clk = ~clk;

    life_next_gen #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .out_stream_aclk (clk),
        .periph_resetn   (periph_resetn),
        .start           (start),
        .pause           (pause),
        .busy            (busy),
        .done            (done),
        .gen_count       (gen_count),
        .rd_en           (rd_en),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data)
    );

    // Source BRAM: one-cycle read latency
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < ROWS) rd_data <= src_mem[rd_addr];
    end

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Grid model in (row, column) coordinates; column 0 is the leftmost cell.
    function automatic int alive(input int r, input int c);
`ifdef LIFE_WRAP_EN
        r = (r + ROWS) % ROWS;
        c = (c + COLS) % COLS;
`else
        if (r < 0 || r >= ROWS || c < 0 || c >= COLS) return 0;
`endif
        return int'(ref_g[r][COLS-1-c]);
    endfunction

    task automatic model_step();
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0) n += alive(r + dr, c + dc);
                if (alive(r, c) == 1) ref_n[r][COLS-1-c] = (n == 2 || n == 3);
                else                  ref_n[r][COLS-1-c] = (n == 3);
            end
        end
        for (int r = 0; r < ROWS; r++) ref_g[r] = ref_n[r];
    endtask

    task automatic set_cell(input int r, input int c);
        ref_g[r][COLS-1-c] = 1'b1;
    endtask

    task automatic sync_src();
        for (int r = 0; r < ROWS; r++) src_mem[r] = ref_g[r];
    endtask

    task automatic load_pattern(input int pat);
        for (int r = 0; r < ROWS; r++) begin
            case (pat)
                2:       ref_g[r] = COLS'($urandom);
                3:       ref_g[r] = '1;
                default: ref_g[r] = '0;
            endcase
        end
        if (pat == 0) for (int c = 10; c <= 12; c++) set_cell(5, c);
        if (pat == 1) for (int i = 0; i < 5; i++) set_cell(ROWS - 3 + gl_r[i], COLS - 3 + gl_c[i]);
        sync_src();
    endtask

    function automatic int row_diff();
        int n = 0;
        for (int r = 0; r < ROWS; r++) if (dst_mem[r] !== ref_g[r]) n++;
        return n;
    endfunction

    function automatic int blinker_diff();
        int n = 0;
        logic [COLS-1:0] e;
        for (int r = 0; r < ROWS; r++) begin
            e = '0;
            if (r >= 4 && r <= 6) e[COLS-1-11] = 1'b1;
            if (dst_mem[r] !== e) n++;
        end
        return n;
    endfunction

    function automatic int glider_wrap_diff();
        int n = 0;
        logic [COLS-1:0] e [ROWS];
        for (int r = 0; r < ROWS; r++) e[r] = '0;
        for (int i = 0; i < 5; i++)
            e[(ROWS - 2 + gl_r[i]) % ROWS][COLS-1-((COLS - 2 + gl_c[i]) % COLS)] = 1'b1;
        for (int r = 0; r < ROWS; r++) if (dst_mem[r] !== e[r]) n++;
        return n;
    endfunction

    function automatic int edge_cells();
        int n = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if ((r < 2 || c < 2) && dst_mem[r][COLS-1-c] !== 1'b0) n++;
        return n;
    endfunction

    // Called just after a clock edge (#1); the next edge samples start and is cycle 0.
    task automatic run_gen(input int p_at, input int p_len, input int s2_at,
                           input int exp_lat, input int exp_pw);
        int c, done_c, done_n, first_b, last_b, rises, pw, gc, done_busy, err;
        int rdq[$];
        int wrq[$];
        int exp_rd[$];
        logic prev_b;
        c = 0; done_c = -1; done_n = 0; first_b = -1; last_b = -1;
        rises = 0; pw = 0; gc = -1; done_busy = -1; prev_b = 1'b0;
        for (int r = 0; r < ROWS; r++) dst_mem[r] = COLS'(32'hA5A5_A5A5);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_cycle0", busy, 0);
        while (c < exp_lat + 30 && (done_c < 0 || c < done_c + 4)) begin
            pause = (p_len > 0) && (c + 1 >= p_at) && (c + 1 < p_at + p_len);
            start = (s2_at > 0) && (c + 1 == s2_at);
            @(posedge clk); #1;
            c++;
            if (rd_en) rdq.push_back(int'(rd_addr));
            if (wr_en) begin
                wrq.push_back(int'(wr_addr));
                if (int'(wr_addr) < ROWS) dst_mem[wr_addr] = wr_data;
                if (p_len > 0 && c > p_at && c < p_at + p_len) pw++;
            end
            if (busy && !prev_b) rises++;
            if (busy) begin
                if (first_b < 0) first_b = c;
                last_b = c;
            end
            prev_b = busy;
            if (done) begin
                done_n++;
                if (done_c < 0) begin
                    done_c = c;
                    done_busy = int'(busy);
                    gc = int'(gen_count);
                end
            end
        end
        pause = 1'b0;
        start = 1'b0;
        exp_gc = (exp_gc + 1) & 16'hFFFF;
        check("done_cycle", done_c, exp_lat);
        check("done_pulses", done_n, 1);
        check("busy_at_done", done_busy, 0);
        check("busy_first", first_b, 1);
        check("busy_last", last_b, exp_lat - 1);
        check("busy_periods", rises, 1);
        check("gen_count", gc, exp_gc);
        err = 0;
        for (int i = 0; i < wrq.size(); i++) if (wrq[i] != i) err++;
        check("wr_count", wrq.size(), ROWS);
        check("wr_order", err, 0);
`ifdef LIFE_WRAP_EN
        for (int k = 0; k <= ROWS + 1; k++) exp_rd.push_back((k + ROWS - 1) % ROWS);
`else
        for (int k = 1; k <= ROWS; k++) exp_rd.push_back(k - 1);
`endif
        err = 0;
        for (int i = 0; i < rdq.size() && i < exp_rd.size(); i++) if (rdq[i] != exp_rd[i]) err++;
        check("rd_count", rdq.size(), exp_rd.size());
        check("rd_order", err, 0);
        if (exp_pw >= 0) check("pause_writes", pw, exp_pw);
    endtask

    initial begin
        periph_resetn = 1'b0;
        start = 1'b0;
        pause = 1'b0;
        vecs[0] = '{0, 2, 0, 0, 0, ROWS + 5, -1};
        vecs[1] = '{1, 4, 0, 0, 0, ROWS + 5, -1};
        vecs[2] = '{2, 1, 8, 6, 0, ROWS + 11, 1};
        vecs[3] = '{2, 1, 2, 3, 0, ROWS + 8, 0};
        vecs[4] = '{2, 1, 0, 0, 12, ROWS + 5, -1};
        vecs[5] = '{3, 1, 0, 0, 0, ROWS + 5, -1};
        vecs[6] = '{4, 1, 0, 0, 0, ROWS + 5, -1};
        vecs[7] = '{2, 3, 0, 0, 0, ROWS + 5, -1};

        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, rd_en, wr_en, gen_count, rd_addr, wr_addr, wr_data}, 0);
        periph_resetn = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < NV; v++) begin
            load_pattern(vecs[v].pat);
            for (int g = 0; g < vecs[v].n_gen; g++) begin
                if (g == 0) run_gen(vecs[v].p_at, vecs[v].p_len, vecs[v].s2_at,
                                    vecs[v].exp_lat, vecs[v].exp_pw);
                else        run_gen(0, 0, 0, ROWS + 5, -1);
                model_step();
                check("next_rows", row_diff(), 0);
                if (vecs[v].pat == 0 && g == 0) check("blinker_vertical", blinker_diff(), 0);
                sync_src();
            end
`ifdef LIFE_WRAP_EN
            if (vecs[v].pat == 1) check("glider_wrapped", glider_wrap_diff(), 0);
`else
            if (vecs[v].pat == 1) check("glider_edge_cells", edge_cells(), 0);
`endif
        end

        // Reset in the middle of a generation, then a clean restart
        load_pattern(2);
        check("gen_count_before_reset", gen_count, exp_gc);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        periph_resetn = 1'b0;
        #1;
        check("midrun_reset_outputs", {busy, done, rd_en, wr_en, gen_count, rd_addr, wr_addr, wr_data}, 0);
        check("midrun_reset_idle", dut.state_q == ST_IDLE, 1);
        @(posedge clk); #1;
        periph_resetn = 1'b1;
        @(posedge clk); #1;
        exp_gc = 0;
        run_gen(0, 0, 0, ROWS + 5, -1);
        model_step();
        check("restart_rows", row_diff(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
